ram_arbiter: RTL and testbench

- Shares the single-ported main RAM between the instruction-fetch stream and the data/coherence stream coming out of the coherence controller.
- Sits between the coherence controller's memory-side interface and the RAM model.
- Grants one requester at a time. Data has priority, with a starvation guard for instruction fetch.
- Holds each grant until the RAM completes, errors, times out, or the request is withdrawn.

---
 rtl/cpu_types_pkg.sv | 13 +
 rtl/ram_arbiter_pkg.sv | 10 +
 rtl/arb_counter.sv | 23 ++
 rtl/ram_arbiter.sv | 148 ++++++++++++++
 tb/tb_ram_arbiter.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types: machine word and RAM model status codes.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/ram_arbiter_pkg.sv
// Local types for the RAM arbiter.
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DGRANT,
        IGRANT
    } arb_state_t;

endpackage

// File: rtl/arb_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module arb_counter #(
    parameter int W   = 8,
    parameter int MAX = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && cnt != W'(MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: data has priority, instruction fetch is
// protected from starvation, and every grant is bounded by a timeout.
module ram_arbiter
    import cpu_types_pkg::*, ram_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  word_t       iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  word_t       daddr,
    input  word_t       dstore,
    output logic        iwait,
    output logic        dwait,
    output word_t       iload,
    output word_t       dload,
    output logic        ramREN,
    output logic        ramWEN,
    output word_t       ramaddr,
    output word_t       ramstore,
    input  word_t       ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    arb_state_t    state;
    arb_state_t    next;
    ramstate_t     rs;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] to_cnt;
    logic          active;
    logic          d_done;
    logic          starve_clr;
    logic          starve_inc;
    logic          to_clr;
    logic          to_inc;

    assign rs = ramstate_t'(ramstate);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next     = state;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        err      = 1'b0;
        active   = 1'b0;
        d_done   = 1'b0;

        unique case (state)
            IDLE: begin
                if (iREN && starve_cnt == SW'(STARVE_LIMIT)) begin
                    next = IGRANT;
                end else if (dREN || dWEN) begin
                    next = DGRANT;
                end else if (iREN) begin
                    next = IGRANT;
                end
            end
            DGRANT: begin
                ramaddr = daddr;
                if (dWEN) begin
                    ramWEN   = 1'b1;
                    ramstore = dstore;
                end else begin
                    ramREN = 1'b1;
                end
                active = dREN || dWEN;
            end
            IGRANT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                active  = iREN;
            end
            default: next = IDLE;
        endcase

        // Exit checks shared by both grants; withdrawal leaves silently.
        if (state != IDLE) begin
            next = IDLE;
            if (active) begin
                if (rs == ERROR) begin
                    err = 1'b1;
                end else if (rs == ACCESS) begin
                    if (state == DGRANT) begin
                        dwait  = 1'b0;
                        dload  = dWEN ? '0 : ramload;
                        d_done = 1'b1;
                    end else begin
                        iwait = 1'b0;
                        iload = ramload;
                    end
                end else if (to_cnt == TW'(TIMEOUT - 1)) begin
                    err = 1'b1;
                end else begin
                    next = state;
                end
            end
        end
    end

    assign starve_clr = !iREN || (state == IDLE && next == IGRANT);
    assign starve_inc = d_done && iREN;
    assign to_clr     = (next == IDLE);
    assign to_inc     = (state != IDLE) && (next != IDLE);

    arb_counter #(
        .W   (SW),
        .MAX (STARVE_LIMIT)
    ) u_starve (
        .clk   (CLK),
        .rst_n (nRST),
        .clr   (starve_clr),
        .inc   (starve_inc),
        .cnt   (starve_cnt)
    );

    arb_counter #(
        .W   (TW),
        .MAX (TIMEOUT - 1)
    ) u_timeout (
        .clk   (CLK),
        .rst_n (nRST),
        .clr   (to_clr),
        .inc   (to_inc),
        .cnt   (to_cnt)
    );

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: randomized and directed traffic
// checked against a transaction-level model of the arbitration rules.
module tb_ram_arbiter;
    import cpu_types_pkg::*;

    localparam int LIMIT = 4;
    localparam int TMO   = 64;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = '0;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] dstore = '0;
    logic        iwait;
    logic        dwait;
    logic [31:0] iload;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload = '0;
    logic [1:0]  ramstate = 2'd0;
    logic        err;

    always #5 CLK = ~CLK;

    ram_arbiter #(
        .STARVE_LIMIT (LIMIT),
        .TIMEOUT      (TMO)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .iwait    (iwait),
        .dwait    (dwait),
        .iload    (iload),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .err      (err)
    );

    // kind: 0 data done, 1 instruction done, 2 error/timeout pulse
    typedef struct {
        int          kind;
        logic [31:0] data;
        int          cyc;
    } ev_t;

    ev_t q[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;

    // owner: 0 nobody, 1 data, 2 instruction
    int owner = 0, age = 0, streak = 0;
    int n_owner = 0, n_age = 0, n_streak = 0;
    logic        e_ren = 1'b0, e_wen = 1'b0;
    logic [31:0] e_addr = '0, e_store = '0;

    task automatic push(input int k, input logic [31:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        e.cyc  = cyc;
        q.push_back(e);
    endtask

    task automatic eval();
        bit act;
        act = 1'b0;
        e_ren = 1'b0;
        e_wen = 1'b0;
        e_addr = '0;
        e_store = '0;
        if (!nRST) begin
            owner = 0; age = 0; streak = 0;
            n_owner = 0; n_age = 0; n_streak = 0;
            return;
        end
        n_owner = owner;
        n_age = age;
        n_streak = iREN ? streak : 0;
        if (owner == 0) begin
            n_age = 0;
            if (iREN && streak == LIMIT) begin
                n_owner = 2; n_streak = 0;
            end else if (dREN || dWEN) begin
                n_owner = 1;
            end else if (iREN) begin
                n_owner = 2; n_streak = 0;
            end
        end else begin
            if (owner == 1) begin
                e_addr = daddr;
                if (dWEN) begin
                    e_wen = 1'b1; e_store = dstore;
                end else begin
                    e_ren = 1'b1;
                end
                act = dREN || dWEN;
            end else begin
                e_ren = 1'b1;
                e_addr = iaddr;
                act = iREN;
            end
            n_owner = 0;
            n_age = 0;
            if (!act) begin
                n_owner = 0;
            end else if (ramstate == ERROR) begin
                push(2, '0);
            end else if (ramstate == ACCESS) begin
                push(owner - 1, (owner == 1 && dWEN) ? 32'h0 : ramload);
                if (owner == 1 && iREN && streak < LIMIT)
                    n_streak = streak + 1;
            end else if (age == TMO - 1) begin
                push(2, '0);
            end else begin
                n_owner = owner;
                n_age = age + 1;
            end
        end
    endtask

    task automatic drive_cycle(input bit rstn, input bit i, input bit dr,
                               input bit dw, input logic [1:0] rs,
                               input logic [31:0] ld);
        @(posedge CLK);
        #1;
        owner = n_owner;
        age = n_age;
        streak = n_streak;
        cyc++;
        nRST = rstn;
        iREN = i;
        dREN = dr;
        dWEN = dw;
        iaddr = $urandom;
        daddr = $urandom;
        dstore = $urandom;
        ramload = ld;
        ramstate = rs;
        eval();
    endtask

    always @(negedge CLK) begin : mon
        ev_t e;
        int k;
        logic [31:0] d;
        tests++;
        if ({ramREN, ramWEN, ramaddr, ramstore} !==
            {e_ren, e_wen, e_addr, e_store}) begin
            fails++;
            $display("FAIL ram_bus cyc %0d: got ren=%b wen=%b addr=%h st=%h, exp ren=%b wen=%b addr=%h st=%h",
                     cyc, ramREN, ramWEN, ramaddr, ramstore,
                     e_ren, e_wen, e_addr, e_store);
        end
        tests++;
        if ((dwait && dload !== 32'h0) || (iwait && iload !== 32'h0)) begin
            fails++;
            $display("FAIL idle_load cyc %0d: got dload=%h iload=%h, exp 0 while waiting",
                     cyc, dload, iload);
        end
        if (!dwait && !iwait) begin
            tests++;
            fails++;
            $display("FAIL both_waits cyc %0d: got both low, exp at most one", cyc);
        end else if (err || !dwait || !iwait) begin
            k = err ? 2 : (!dwait ? 0 : 1);
            d = !dwait ? dload : (!iwait ? iload : 32'h0);
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event cyc %0d: got kind=%0d data=%h, exp none",
                         cyc, k, d);
            end else begin
                e = q.pop_front();
                if (e.kind != k || e.cyc != cyc || e.data !== d) begin
                    fails++;
                    $display("FAIL event cyc %0d: got kind=%0d data=%h, exp kind=%0d data=%h cyc=%0d",
                             cyc, k, d, e.kind, e.data, e.cyc);
                end
            end
        end else if (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            tests++;
            fails++;
            $display("FAIL missing_event cyc %0d: got nothing, exp kind=%0d data=%h",
                     cyc, e.kind, e.data);
        end
    end

    initial begin
        bit ri, rd, rw;
        int r;
        logic [1:0] rs;

        repeat (2) drive_cycle(0, 0, 0, 0, FREE, 32'h0);
        tests++;
        if ({iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err} !==
            {1'b1, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0}) begin
            fails++;
            $display("FAIL reset_state: got iw=%b dw=%b ren=%b wen=%b err=%b, exp 1 1 0 0 0",
                     iwait, dwait, ramREN, ramWEN, err);
        end

        // single data read
        drive_cycle(1, 0, 1, 0, FREE, 32'h0);
        drive_cycle(1, 0, 1, 0, BUSY, 32'h0);
        drive_cycle(1, 0, 1, 0, BUSY, 32'h0);
        drive_cycle(1, 0, 1, 0, ACCESS, 32'hDEADBEEF);
        drive_cycle(1, 0, 0, 0, FREE, 32'h0);

        // simultaneous write and fetch
        drive_cycle(1, 1, 0, 1, FREE, 32'h0);
        drive_cycle(1, 1, 0, 1, BUSY, 32'h0);
        drive_cycle(1, 1, 0, 1, ACCESS, 32'h55AA55AA);
        drive_cycle(1, 1, 0, 0, FREE, 32'h0);
        drive_cycle(1, 1, 0, 0, BUSY, 32'h0);
        drive_cycle(1, 1, 0, 0, ACCESS, 32'hCAFE0040);
        drive_cycle(1, 0, 0, 0, FREE, 32'h0);

        // starvation guard
        for (int n = 0; n < 40; n++)
            drive_cycle(1, 1, 1, 0, ACCESS, $urandom);
        drive_cycle(1, 0, 0, 0, FREE, 32'h0);

        // RAM error then re-grant
        drive_cycle(1, 0, 1, 0, FREE, 32'h0);
        drive_cycle(1, 0, 1, 0, BUSY, 32'h0);
        drive_cycle(1, 0, 1, 0, ERROR, 32'h0);
        drive_cycle(1, 0, 1, 0, FREE, 32'h0);
        drive_cycle(1, 0, 1, 0, ACCESS, 32'h13572468);
        drive_cycle(1, 0, 0, 0, FREE, 32'h0);

        // timeout on a stuck fetch
        for (int n = 0; n < 140; n++)
            drive_cycle(1, 1, 0, 0, BUSY, 32'h0);
        drive_cycle(1, 0, 0, 0, FREE, 32'h0);

        // withdrawal, then reset in the middle of a grant
        drive_cycle(1, 0, 1, 0, FREE, 32'h0);
        drive_cycle(1, 0, 1, 0, BUSY, 32'h0);
        drive_cycle(1, 0, 0, 0, BUSY, 32'h0);
        drive_cycle(1, 0, 0, 0, FREE, 32'h0);
        drive_cycle(1, 0, 1, 0, FREE, 32'h0);
        drive_cycle(1, 0, 1, 0, BUSY, 32'h0);
        drive_cycle(0, 0, 1, 0, ACCESS, 32'h0BADF00D);
        drive_cycle(0, 0, 1, 0, ACCESS, 32'h0BADF00D);
        drive_cycle(1, 0, 1, 0, FREE, 32'h0);
        drive_cycle(1, 0, 1, 0, BUSY, 32'h0);
        drive_cycle(1, 0, 1, 0, ACCESS, 32'h2468ACE0);
        drive_cycle(1, 0, 0, 0, FREE, 32'h0);

        // randomized traffic
        ri = 1'b0; rd = 1'b0; rw = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0) ri = !ri;
            if ($urandom_range(0, 5) == 0) rd = !rd;
            if ($urandom_range(0, 7) == 0) rw = !rw;
            r = $urandom_range(0, 99);
            rs = (r < 40) ? BUSY : (r < 55) ? FREE : (r < 95) ? ACCESS : ERROR;
            drive_cycle($urandom_range(0, 299) != 0, ri, rd, rw, rs, $urandom);
        end

        repeat (4) drive_cycle(1, 0, 0, 0, FREE, 32'h0);
        @(posedge CLK);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending events, exp 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
